alarm_trigger: RTL and testbench
================================

# alarm_trigger

Downstream consumer of the alarm-time setting counters (second, minute, hour) and of the running time-of-day counters. It compares the current time with the stored alarm time once per second. On a match it drives a ringing/snooze state machine that produces the buzzer enable and status LEDs. Auto-stop, snooze and the snooze limit are all counted in whole seconds from the time-of-day second strobe.

## Interface

Parameters:
- RING_SECS, 60, seconds a ring lasts before auto-stop (1..255)
- SNOOZE_SECS, 240, seconds spent in snooze before re-ringing (1..255)
- MAX_SNOOZE, 3, snoozes allowed per alarm event (0..7)

Ports:
- clock  in  1  design clock, the same divided clock that drives the time and alarm counters
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- alarm_on  in  1  arm switch, level
- sec_tick  in  1  one-cycle pulse, one per elapsed second of time-of-day
- cur_hour  in  5  current hour, 0..23
- cur_min  in  6  current minute, 0..59
- cur_sec  in  6  current second, 0..59
- alm_hour  in  5  alarm hour
- alm_min  in  6  alarm minute
- alm_sec  in  6  alarm second
- stop_btn  in  1  one-cycle pulse (debounced upstream)
- snooze_btn  in  1  one-cycle pulse (debounced upstream)
- buzzer  out  1  buzzer drive, registered
- ringing  out  1  high in RING, registered
- snoozing  out  1  high in SNOOZE, registered

## Operation

- States: IDLE, RING, SNOOZE. One shared seconds timer `tmr` (8 bit) and a snooze counter `snz_cnt` (3 bit).
- match = alarm_on & sec_tick & (cur_hour==alm_hour) & (cur_min==alm_min) & (cur_sec==alm_sec).
- IDLE:
  - On match, go to RING with tmr=0, snz_cnt=0 and buzzer phase=1.
  - All other inputs are ignored.
- RING:
  - Each sec_tick increments tmr and toggles the buzzer phase (1 Hz beep: on 1 s, off 1 s).
  - When sec_tick arrives with tmr==RING_SECS-1, go to IDLE (auto-stop).
  - On snooze_btn with snz_cnt<MAX_SNOOZE, go to SNOOZE with tmr=0 and snz_cnt+1.
  - When snz_cnt==MAX_SNOOZE, snooze_btn is ignored.
  - stop_btn goes to IDLE.
  - match is ignored.
- SNOOZE:
  - Each sec_tick increments tmr.
  - When sec_tick arrives with tmr==SNOOZE_SECS-1, go to RING with tmr=0 and phase=1. snz_cnt is kept.
  - stop_btn goes to IDLE.
  - snooze_btn and match are ignored.
- Priority within one cycle, highest first: reset, alarm_on==0, stop_btn, snooze_btn, timer expiry, match.
  - alarm_on==0 forces IDLE from any state.
  - stop_btn together with snooze_btn resolves to stop.
  - snooze_btn on the same cycle as ring expiry resolves to snooze.
- Outputs:
  - buzzer = (state==RING) & phase.
  - ringing = (state==RING).
  - snoozing = (state==SNOOZE).
- Time inputs are sampled only on sec_tick cycles. Values between ticks are don't-care.

## Timing

- Reset: state=IDLE, tmr=0, snz_cnt=0, phase=0, and buzzer=ringing=snoozing=0 on the cycle after reset is sampled high. Reset mid-RING or mid-SNOOZE aborts immediately.
- Latency:
  - match on cycle N gives ringing=buzzer=1 at N+1.
  - stop_btn or snooze_btn on cycle N takes effect at N+1.
- Ring duration is exactly RING_SECS sec_ticks, counting the first tick after the entry cycle. With RING_SECS=60 there are 30 on-seconds and 30 off-seconds.
- A match tick also counts as the time-of-day second. tmr does not advance on the entry cycle.
- Comparison uses exact equality. There is no wrap handling beyond the counters' own 59→0 and 23→0.

## Structure

- Shared package alarm_pkg holds:
  - the state enum (IDLE, RING, SNOOZE);
  - the width constants HOUR_W=5, MIN_W=6, SEC_W=6, TMR_W=8, SNZ_W=3.
- Single module, no sub-module. The FSM, tmr, snz_cnt and the phase register sit in one sequential block with a separate next-state block.

## Test plan

Bench parameters: RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=1.

- **Match and auto-stop.** Set alarm and current time to 07:30:00 with alarm_on=1 and pulse sec_tick. Required: ringing=1 on the next cycle; buzzer goes 1,0,1,0 across the following ticks; IDLE after the 4th tick.
- **Disarmed match.** Same match with alarm_on=0. Required: state stays IDLE and all outputs stay 0.
- **Snooze then re-ring.** Snooze on the 2nd ring second. Required: snoozing=1 for 3 ticks, then ringing=1 with buzzer=1. A second snooze_btn is ignored; stop_btn then returns to IDLE.
- **Simultaneous buttons.** stop_btn and snooze_btn on the same cycle in RING. Required: IDLE, snoozing stays 0.
- **Disarm mid-alarm.** alarm_on dropped during SNOOZE. Required: IDLE next cycle and no re-ring after 3 ticks.
- **Reset mid-ring.** Assert reset while in RING. Required: all outputs 0 next cycle; a later match rings again with snz_cnt=0.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and field widths for the alarm comparison and ring/snooze control.
package alarm_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int TMR_W  = 8;
    localparam int SNZ_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_t;

endpackage

// File: rtl/alarm_trigger.sv
// Compares time-of-day with the stored alarm time on each second strobe and runs
// the ring/snooze state machine that drives the buzzer and status outputs.
module alarm_trigger
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 240,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alarm_on,
    input  logic              sec_tick,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic [HOUR_W-1:0] alm_hour,
    input  logic [MIN_W-1:0]  alm_min,
    input  logic [SEC_W-1:0]  alm_sec,
    input  logic              stop_btn,
    input  logic              snooze_btn,
    output logic              buzzer,
    output logic              ringing,
    output logic              snoozing
);

    localparam logic [TMR_W-1:0] RING_LAST   = TMR_W'(RING_SECS - 1);
    localparam logic [TMR_W-1:0] SNOOZE_LAST = TMR_W'(SNOOZE_SECS - 1);
    localparam logic [SNZ_W-1:0] SNZ_LIMIT   = SNZ_W'(MAX_SNOOZE);

    alarm_state_t     state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [SNZ_W-1:0] snz_cnt, snz_nxt;
    logic             phase, phase_nxt;
    logic             match;

    assign match = alarm_on & sec_tick & (cur_hour == alm_hour)
                 & (cur_min == alm_min) & (cur_sec == alm_sec);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path holds a stale value as a latch.
        state_nxt = state;
        tmr_nxt   = tmr;
        snz_nxt   = snz_cnt;
        phase_nxt = phase;

        if (!alarm_on) begin
            state_nxt = IDLE;
            tmr_nxt   = '0;
            phase_nxt = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (match) begin
                        state_nxt = RING;
                        tmr_nxt   = '0;
                        snz_nxt   = '0;
                        phase_nxt = 1'b1;
                    end
                end
                RING: begin
                    if (stop_btn) begin
                        state_nxt = IDLE;
                        tmr_nxt   = '0;
                        phase_nxt = 1'b0;
                    end else if (snooze_btn && (snz_cnt < SNZ_LIMIT)) begin
                        state_nxt = SNOOZE;
                        tmr_nxt   = '0;
                        snz_nxt   = snz_cnt + 1'b1;
                    end else if (sec_tick) begin
                        if (tmr == RING_LAST) begin
                            state_nxt = IDLE;
                            tmr_nxt   = '0;
                            phase_nxt = 1'b0;
                        end else begin
                            tmr_nxt   = tmr + 1'b1;
                            phase_nxt = ~phase;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        state_nxt = IDLE;
                        tmr_nxt   = '0;
                        phase_nxt = 1'b0;
                    end else if (sec_tick) begin
                        // Re-ring keeps snz_cnt so the limit spans the whole alarm event.
                        if (tmr == SNOOZE_LAST) begin
                            state_nxt = RING;
                            tmr_nxt   = '0;
                            phase_nxt = 1'b1;
                        end else begin
                            tmr_nxt = tmr + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                    phase_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state    <= IDLE;
            tmr      <= '0;
            snz_cnt  <= '0;
            phase    <= 1'b0;
            buzzer   <= 1'b0;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            snz_cnt  <= snz_nxt;
            phase    <= phase_nxt;
            // Outputs are decoded from next-state values so they line up with the state register.
            buzzer   <= (state_nxt == RING) & phase_nxt;
            ringing  <= (state_nxt == RING);
            snoozing <= (state_nxt == SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed self-checking bench for alarm_trigger with short ring/snooze timings.
module tb_alarm_trigger;

    logic       clock;
    logic       reset;
    logic       alarm_on;
    logic       sec_tick;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [4:0] alm_hour;
    logic [5:0] alm_min;
    logic [5:0] alm_sec;
    logic       stop_btn;
    logic       snooze_btn;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;

    int checks = 0;
    int errors = 0;

    alarm_trigger #(
        .RING_SECS  (4),
        .SNOOZE_SECS(3),
        .MAX_SNOOZE (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .alarm_on  (alarm_on),
        .sec_tick  (sec_tick),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .alm_hour  (alm_hour),
        .alm_min   (alm_min),
        .alm_sec   (alm_sec),
        .stop_btn  (stop_btn),
        .snooze_btn(snooze_btn),
        .buzzer    (buzzer),
        .ringing   (ringing),
        .snoozing  (snoozing)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic check_out(input string tag, input logic exp_buz, input logic exp_ring,
                             input logic exp_snz);
        check({tag, ".buzzer"}, buzzer, exp_buz);
        check({tag, ".ringing"}, ringing, exp_ring);
        check({tag, ".snoozing"}, snoozing, exp_snz);
    endtask

    // One clock with the given pulses; outputs are examined 1 ns after the edge.
    task automatic cyc(input logic tk, input logic st, input logic sz);
        sec_tick   = tk;
        stop_btn   = st;
        snooze_btn = sz;
        @(posedge clock);
        #1;
        sec_tick   = 1'b0;
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        if (tk) cur_sec = (cur_sec == 6'd59) ? 6'd0 : cur_sec + 6'd1;
    endtask

    initial begin
        reset      = 1'b1;
        alarm_on   = 1'b0;
        sec_tick   = 1'b0;
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        cur_hour   = 5'd7;
        cur_min    = 6'd30;
        cur_sec    = 6'd10;
        alm_hour   = 5'd7;
        alm_min    = 6'd30;
        alm_sec    = 6'd0;

        cyc(0, 0, 0);
        check_out("reset", 0, 0, 0);
        reset = 1'b0;
        cyc(0, 0, 0);
        check_out("post_reset", 0, 0, 0);

        // Match and auto-stop after four ring seconds.
        alarm_on = 1'b1;
        cur_sec  = 6'd0;
        cyc(1, 0, 0);
        check_out("match_entry", 1, 1, 0);
        cyc(0, 0, 0);
        check_out("hold_between_ticks", 1, 1, 0);
        cyc(1, 0, 0);
        check_out("ring_tick1", 0, 1, 0);
        cyc(1, 0, 0);
        check_out("ring_tick2", 1, 1, 0);
        cyc(1, 0, 0);
        check_out("ring_tick3", 0, 1, 0);
        cyc(1, 0, 0);
        check_out("auto_stop", 0, 0, 0);
        cyc(1, 0, 0);
        check_out("idle_after_stop", 0, 0, 0);

        // Disarmed match.
        alarm_on = 1'b0;
        cur_sec  = 6'd0;
        cyc(1, 0, 0);
        check_out("disarmed_match", 0, 0, 0);
        cyc(1, 0, 0);
        check_out("disarmed_tick", 0, 0, 0);
        alarm_on = 1'b1;

        // Snooze on the 2nd ring second, re-ring, ignored second snooze, stop.
        cur_sec = 6'd0;
        cyc(1, 0, 0);
        check_out("snz_match", 1, 1, 0);
        cyc(1, 0, 0);
        check_out("snz_ring_sec2", 0, 1, 0);
        cyc(0, 0, 1);
        check_out("snooze_press", 0, 0, 1);
        cyc(1, 0, 0);
        check_out("snooze_tick1", 0, 0, 1);
        cyc(1, 0, 0);
        check_out("snooze_tick2", 0, 0, 1);
        cyc(1, 0, 0);
        check_out("re_ring", 1, 1, 0);
        cyc(0, 0, 1);
        check_out("snooze_limit", 1, 1, 0);
        cyc(1, 0, 0);
        check_out("re_ring_tick1", 0, 1, 0);
        cyc(0, 1, 0);
        check_out("stop_press", 0, 0, 0);

        // Stop and snooze together resolve to stop.
        cur_sec = 6'd0;
        cyc(1, 0, 0);
        check_out("both_match", 1, 1, 0);
        cyc(0, 1, 1);
        check_out("both_buttons", 0, 0, 0);

        // Disarm during snooze, then re-arm: no re-ring afterwards.
        cur_sec = 6'd0;
        cyc(1, 0, 0);
        check_out("disarm_match", 1, 1, 0);
        cyc(0, 0, 1);
        check_out("disarm_snooze", 0, 0, 1);
        alarm_on = 1'b0;
        cyc(0, 0, 0);
        check_out("disarm_now", 0, 0, 0);
        alarm_on = 1'b1;
        cyc(1, 0, 0);
        check_out("disarm_tick1", 0, 0, 0);
        cyc(1, 0, 0);
        check_out("disarm_tick2", 0, 0, 0);
        cyc(1, 0, 0);
        check_out("disarm_tick3", 0, 0, 0);

        // Reset mid-ring, then a fresh match rings and snooze is available again.
        cur_sec = 6'd0;
        cyc(1, 0, 0);
        check_out("rst_match", 1, 1, 0);
        cyc(1, 0, 0);
        check_out("rst_ring_tick", 0, 1, 0);
        reset = 1'b1;
        cyc(0, 0, 0);
        check_out("mid_ring_reset", 0, 0, 0);
        reset   = 1'b0;
        cur_sec = 6'd0;
        cyc(1, 0, 0);
        check_out("rematch", 1, 1, 0);
        cyc(0, 0, 1);
        check_out("rematch_snooze", 0, 0, 1);
        cyc(0, 1, 0);
        check_out("rematch_stop", 0, 0, 0);

        // Snooze on the same cycle as ring expiry resolves to snooze.
        cur_sec = 6'd0;
        cyc(1, 0, 0);
        check_out("exp_match", 1, 1, 0);
        cyc(1, 0, 0);
        check_out("exp_tick1", 0, 1, 0);
        cyc(1, 0, 0);
        check_out("exp_tick2", 1, 1, 0);
        cyc(1, 0, 0);
        check_out("exp_tick3", 0, 1, 0);
        cyc(1, 0, 1);
        check_out("expiry_vs_snooze", 0, 0, 1);
        cyc(0, 1, 0);
        check_out("exp_stop", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
